// File: rtl/mux_uart_pkg.sv
// Shared definitions for the memory-mapped multi-channel UART: register offsets,
// status byte layout and FSM state encodings.
package mux_uart_pkg;

   localparam int unsigned STAT_OFS = 0;
   localparam int unsigned DATA_OFS = 1;

   typedef struct packed {
      logic [2:0] rsvd;
      logic       framerr;
      logic       overrun;
      logic       txidle;
      logic       txrdy;
      logic       rxrdy;
   } status_t;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/mux_uart_channel.sv
// One 8N1 channel: TX FIFO feeding a TX shifter, RX deserialiser with a holding
// register, and the live status byte.
module mux_uart_channel
   import mux_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned TX_DEPTH     = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       wr_data,
   input  logic       rd_data,
   input  logic       rd_stat,
   input  logic [7:0] data_in,
   input  logic       rx,
   output logic       tx,
   output logic [7:0] status_c,
   output logic [7:0] rx_data
);

   localparam int unsigned AW    = $clog2(TX_DEPTH);
   localparam int unsigned CW    = AW + 1;
   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

   logic [7:0]    fifo_mem [TX_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          fifo_full, fifo_empty, push, pop;

   // A full FIFO still accepts a write when the shifter pops in the same cycle
   assign fifo_full  = (count == CW'(TX_DEPTH));
   assign fifo_empty = (count == '0);
   assign push       = wr_data && (!fifo_full || pop);

   always_ff @(posedge clock) begin
      if (push) fifo_mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   tx_state_t        tx_state, tx_next;
   logic [CNT_W-1:0] tx_cnt, tx_cnt_n;
   logic [2:0]       tx_bit, tx_bit_n;
   logic [7:0]       tx_sh, tx_sh_n;
   logic             tx_n;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_sh    <= '0;
         tx       <= 1'b1;
      end else begin
         tx_state <= tx_next;
         tx_cnt   <= tx_cnt_n;
         tx_bit   <= tx_bit_n;
         tx_sh    <= tx_sh_n;
         tx       <= tx_n;
      end
   end

   // tx is registered from the next state so the line tracks the FSM exactly
   always_comb begin
      tx_next  = tx_state;
      tx_cnt_n = tx_cnt;
      tx_bit_n = tx_bit;
      tx_sh_n  = tx_sh;
      pop      = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            if (!fifo_empty) begin
               pop      = 1'b1;
               tx_sh_n  = fifo_mem[rd_ptr];
               tx_cnt_n = '0;
               tx_next  = TX_START;
            end
         end
         TX_START: begin
            if (tx_cnt == BIT_END) begin
               tx_cnt_n = '0;
               tx_bit_n = '0;
               tx_next  = TX_DATA;
            end else tx_cnt_n = tx_cnt + 1'b1;
         end
         TX_DATA: begin
            if (tx_cnt == BIT_END) begin
               tx_cnt_n = '0;
               tx_sh_n  = {1'b0, tx_sh[7:1]};
               if (tx_bit == 3'd7) tx_next = TX_STOP;
               else tx_bit_n = tx_bit + 1'b1;
            end else tx_cnt_n = tx_cnt + 1'b1;
         end
         TX_STOP: begin
            if (tx_cnt == BIT_END) begin
               tx_cnt_n = '0;
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  tx_sh_n = fifo_mem[rd_ptr];
                  tx_next = TX_START;
               end else tx_next = TX_IDLE;
            end else tx_cnt_n = tx_cnt + 1'b1;
         end
         default: tx_next = TX_IDLE;
      endcase
      case (tx_next)
         TX_START: tx_n = 1'b0;
         TX_DATA:  tx_n = tx_sh_n[0];
         default:  tx_n = 1'b1;
      endcase
   end

   logic [1:0]       rx_sync;
   logic             rx_s, rx_prev;
   rx_state_t        rx_state, rx_next;
   logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
   logic [2:0]       rx_bit, rx_bit_n;
   logic [7:0]       rx_sh, rx_sh_n;
   logic             rx_load, rx_bad_stop;
   logic             rx_rdy, overrun, framerr;

   assign rx_s = rx_sync[1];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_sync  <= 2'b11;
         rx_prev  <= 1'b1;
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_sh    <= '0;
      end else begin
         rx_sync  <= {rx_sync[0], rx};
         rx_prev  <= rx_s;
         rx_state <= rx_next;
         rx_cnt   <= rx_cnt_n;
         rx_bit   <= rx_bit_n;
         rx_sh    <= rx_sh_n;
      end
   end

   // Edge-triggered start so a low stop bit cannot re-arm the receiver
   always_comb begin
      rx_next     = rx_state;
      rx_cnt_n    = rx_cnt;
      rx_bit_n    = rx_bit;
      rx_sh_n     = rx_sh;
      rx_load     = 1'b0;
      rx_bad_stop = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (rx_prev && !rx_s) begin
               rx_cnt_n = '0;
               rx_next  = RX_START;
            end
         end
         RX_START: begin
            if (rx_cnt == HALF_END) begin
               rx_cnt_n = '0;
               rx_bit_n = '0;
               rx_next  = rx_s ? RX_IDLE : RX_DATA;
            end else rx_cnt_n = rx_cnt + 1'b1;
         end
         RX_DATA: begin
            if (rx_cnt == BIT_END) begin
               rx_cnt_n = '0;
               rx_sh_n  = {rx_s, rx_sh[7:1]};
               if (rx_bit == 3'd7) rx_next = RX_STOP;
               else rx_bit_n = rx_bit + 1'b1;
            end else rx_cnt_n = rx_cnt + 1'b1;
         end
         RX_STOP: begin
            if (rx_cnt == BIT_END) begin
               rx_cnt_n    = '0;
               rx_load     = 1'b1;
               rx_bad_stop = !rx_s;
               rx_next     = RX_IDLE;
            end else rx_cnt_n = rx_cnt + 1'b1;
         end
         default: rx_next = RX_IDLE;
      endcase
   end

   // A load beats a same-cycle read clear
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_data <= '0;
         rx_rdy  <= 1'b0;
         overrun <= 1'b0;
         framerr <= 1'b0;
      end else begin
         if (rx_load) begin
            rx_data <= rx_sh;
            rx_rdy  <= 1'b1;
         end else if (rd_data) rx_rdy <= 1'b0;
         if (rx_load && rx_rdy)          overrun <= 1'b1;
         else if (rd_stat)               overrun <= 1'b0;
         if (rx_load && rx_bad_stop)     framerr <= 1'b1;
         else if (rd_stat)               framerr <= 1'b0;
      end
   end

   status_t st;
   always_comb begin
      st         = '0;
      st.rxrdy   = rx_rdy;
      st.txrdy   = !fifo_full;
      st.txidle  = fifo_empty && (tx_state == TX_IDLE);
      st.overrun = overrun;
      st.framerr = framerr;
   end
   assign status_c = st;

endmodule

// File: rtl/mux_uart.sv
// Memory-mapped serial MUX: decodes a window of status/data register pairs onto
// CHANNELS independent UART channels.
module mux_uart
   import mux_uart_pkg::*;
#(
   parameter logic [18:0] BASE_ADDR    = 19'h3f200,
   parameter int unsigned CHANNELS     = 1,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned TX_DEPTH     = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [18:0]         address,
   input  logic                write_en,
   input  logic                read_en,
   input  logic [7:0]          data_in,
   output logic [7:0]          data_out,
   output logic                hit,
   output logic [CHANNELS-1:0] tx,
   input  logic [CHANNELS-1:0] rx
);

   localparam logic [18:0] SPAN = 19'(2 * CHANNELS);

   logic [18:0] offset;
   logic [17:0] ch_sel;
   logic        is_data, is_stat;
   logic [7:0]  status_arr [CHANNELS];
   logic [7:0]  rxd_arr    [CHANNELS];

   assign offset  = address - BASE_ADDR;
   assign hit     = (address >= BASE_ADDR) && (offset < SPAN);
   assign ch_sel  = offset[18:1];
   assign is_data = (offset[0] == 1'(DATA_OFS));
   assign is_stat = (offset[0] == 1'(STAT_OFS));

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic sel;
      assign sel = hit && (ch_sel == 18'(c));

      mux_uart_channel #(
         .CLKS_PER_BIT (CLKS_PER_BIT),
         .TX_DEPTH     (TX_DEPTH)
      ) u_ch (
         .clock    (clock),
         .reset    (reset),
         .wr_data  (sel && write_en && is_data),
         .rd_data  (sel && read_en && is_data),
         .rd_stat  (sel && read_en && is_stat),
         .data_in  (data_in),
         .rx       (rx[c]),
         .tx       (tx[c]),
         .status_c (status_arr[c]),
         .rx_data  (rxd_arr[c])
      );
   end

   always_comb begin
      data_out = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (hit && (ch_sel == 18'(c))) data_out = is_data ? rxd_arr[c] : status_arr[c];
      end
   end

endmodule

// File: tb/tb_mux_uart.sv
// Directed and randomized checks of mux_uart with 2 channels, 4 clocks per bit
// and a 4-entry TX FIFO, against a queue/flag model of the UART behaviour.
module tb_mux_uart;

   localparam int unsigned CPB = 4;
   localparam logic [18:0] A_ST0 = 19'h3f200;
   localparam logic [18:0] A_D0  = 19'h3f201;
   localparam logic [18:0] A_ST1 = 19'h3f202;
   localparam logic [18:0] A_D1  = 19'h3f203;

   logic        clock = 1'b0;
   logic        reset;
   logic [18:0] address;
   logic        write_en, read_en;
   logic [7:0]  data_in, data_out;
   logic        hit;
   logic [1:0]  tx, rx;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   bit mon_en;

   logic [7:0] got0[$], got1[$], exp0[$], exp1[$];
   int         st0[$];

   mux_uart #(
      .BASE_ADDR    (19'h3f200),
      .CHANNELS     (2),
      .CLKS_PER_BIT (CPB),
      .TX_DEPTH     (4)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .address  (address),
      .write_en (write_en),
      .read_en  (read_en),
      .data_in  (data_in),
      .data_out (data_out),
      .hit      (hit),
      .tx       (tx),
      .rx       (rx)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
   endtask

   task automatic peek(input logic [18:0] a, output logic [7:0] d);
      @(negedge clock);
      address = a;
      #1 d = data_out;
   endtask

   task automatic rd(input logic [18:0] a, output logic [7:0] d);
      address = a;
      read_en = 1'b1;
      #1 d = data_out;
      @(negedge clock);
      read_en = 1'b0;
   endtask

   task automatic wr(input logic [18:0] a, input logic [7:0] d);
      address  = a;
      data_in  = d;
      write_en = 1'b1;
      @(negedge clock);
      write_en = 1'b0;
   endtask

   task automatic send_rx(input int ch, input logic [7:0] b, input logic stop);
      rx[ch] = 1'b0;
      repeat (CPB) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         rx[ch] = b[i];
         repeat (CPB) @(negedge clock);
      end
      rx[ch] = stop;
      repeat (CPB) @(negedge clock);
      rx[ch] = 1'b1;
   endtask

   // Decode 8N1 frames from a tx line by mid-bit sampling
   task automatic tx_mon(input int ch);
      logic [7:0] b;
      int t0;
      forever begin
         @(negedge clock);
         if (mon_en && !reset && tx[ch] === 1'b0) begin
            t0 = cyc;
            repeat (CPB / 2) @(negedge clock);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clock);
               b[i] = tx[ch];
            end
            repeat (CPB) @(negedge clock);
            if (ch == 0) begin
               got0.push_back(b);
               st0.push_back(t0);
            end else got1.push_back(b);
         end
      end
   endtask

   initial tx_mon(0);
   initial tx_mon(1);

   task automatic wait_tx_idle(input int limit);
      logic [7:0] s0, s1;
      int n;
      n = 0;
      do begin
         peek(A_ST0, s0);
         peek(A_ST1, s1);
         n++;
      end while (!(s0[2] && s1[2]) && n < limit);
      chk("tx_idle_wait", 32'(n < limit), 32'd1);
   endtask

   task automatic cmp_q(input int ch);
      logic [7:0] g[$], e[$];
      if (ch == 0) begin g = got0; e = exp0; end
      else begin g = got1; e = exp1; end
      chk($sformatf("tx%0d_frames", ch), 32'(g.size()), 32'(e.size()));
      for (int i = 0; i < e.size() && i < g.size(); i++)
         chk($sformatf("tx%0d_byte%0d", ch, i), 32'(g[i]), 32'(e[i]));
   endtask

   initial begin
      logic [7:0] d, b;
      logic [9:0] frame;
      logic [1:0] m_rdy, m_ovr;
      logic [7:0] m_hold [2];
      int ch, n, lows;

      reset = 1'b1; address = '0; write_en = 1'b0; read_en = 1'b0;
      data_in = '0; rx = 2'b11; mon_en = 1'b1;
      repeat (3) @(negedge clock);
      chk("tx_in_reset", 32'(tx), 32'h3);
      reset = 1'b0;

      // reset state and address decode
      peek(A_ST0, d);   chk("rst_status0", 32'(d), 32'h06);
      peek(A_ST1, d);   chk("rst_status1", 32'(d), 32'h06);
      chk("rst_tx", 32'(tx), 32'h3);
      peek(19'h3f1ff, d);
      chk("below_hit", 32'(hit), 32'h0);
      chk("below_data", 32'(d), 32'h0);
      peek(19'h3f204, d);
      chk("above_hit", 32'(hit), 32'h0);
      peek(A_D1, d);
      chk("last_hit", 32'(hit), 32'h1);

      // single frame bit timing
      frame = {1'b1, 8'h48, 1'b0};
      wr(A_D0, 8'h48);
      address = A_ST0;
      @(negedge clock);
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("frame_bit%0d", k), 32'(tx[0]), 32'(frame[k]));
         if (k == 0) chk("tx1_idle", 32'(tx[1]), 32'h1);
         if (k == 5) chk("status_busy", 32'(data_out), 32'h02);
         repeat (CPB) @(negedge clock);
      end
      chk("status_after_frame", 32'(data_out), 32'h06);

      // back-to-back burst with FIFO overflow
      got0.delete(); st0.delete(); exp0.delete();
      for (int i = 0; i < 6; i++) begin
         b = 8'($urandom);
         if (i < 5) exp0.push_back(b);
         wr(A_D0, b);
      end
      peek(A_ST0, d);
      chk("status_full", 32'(d), 32'h00);
      wait_tx_idle(600);
      cmp_q(0);
      for (int i = 0; i + 1 < st0.size(); i++)
         chk($sformatf("frame_gap%0d", i), 32'(st0[i+1] - st0[i]), 32'(10 * CPB));

      // RX on channel 1
      send_rx(1, 8'hA5, 1'b1);
      repeat (4) @(negedge clock);
      peek(A_ST1, d);  chk("rx1_status", 32'(d), 32'h07);
      rd(A_D1, d);     chk("rx1_data", 32'(d), 32'hA5);
      peek(A_ST1, d);  chk("rx1_status_clr", 32'(d), 32'h06);

      // overrun and framing error on channel 0
      send_rx(0, 8'h11, 1'b1);
      send_rx(0, 8'h22, 1'b1);
      repeat (4) @(negedge clock);
      peek(A_ST0, d);  chk("ovr_status", 32'(d), 32'h0F);
      peek(A_D0, d);   chk("ovr_data", 32'(d), 32'h22);
      rd(A_ST0, d);    chk("ovr_status_rd", 32'(d), 32'h0F);
      peek(A_ST0, d);  chk("ovr_cleared", 32'(d), 32'h07);
      rd(A_D0, d);     chk("ovr_data_rd", 32'(d), 32'h22);
      send_rx(0, 8'h5A, 1'b0);
      repeat (4) @(negedge clock);
      peek(A_ST0, d);  chk("ferr_status", 32'(d), 32'h17);
      rd(A_D0, d);     chk("ferr_data", 32'(d), 32'h5A);
      rd(A_ST0, d);    chk("ferr_status_rd", 32'(d), 32'h16);
      peek(A_ST0, d);  chk("ferr_cleared", 32'(d), 32'h06);

      // randomized TX bursts on both channels
      got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
      for (int it = 0; it < 4; it++) begin
         ch = int'($urandom_range(0, 1));
         n  = int'($urandom_range(1, 5));
         for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (ch == 0) exp0.push_back(b); else exp1.push_back(b);
            wr(ch == 0 ? A_D0 : A_D1, b);
         end
         wait_tx_idle(600);
      end
      cmp_q(0);
      cmp_q(1);

      // randomized RX frames with random reads, against a flag model
      m_rdy = 2'b00; m_ovr = 2'b00;
      m_hold[0] = 8'h5A; m_hold[1] = 8'hA5;
      for (int it = 0; it < 8; it++) begin
         ch = int'($urandom_range(0, 1));
         b  = 8'($urandom);
         send_rx(ch, b, 1'b1);
         repeat (4) @(negedge clock);
         m_ovr[ch] = m_ovr[ch] | m_rdy[ch];
         m_rdy[ch] = 1'b1;
         m_hold[ch] = b;
         for (int k = 0; k < 2; k++) begin
            peek(k == 0 ? A_ST0 : A_ST1, d);
            chk($sformatf("rnd%0d_status%0d", it, k), 32'(d),
                32'({4'b0, m_ovr[k], 1'b1, 1'b1, m_rdy[k]}));
            peek(k == 0 ? A_D0 : A_D1, d);
            chk($sformatf("rnd%0d_data%0d", it, k), 32'(d), 32'(m_hold[k]));
         end
         case ($urandom_range(0, 2))
            0: begin rd(ch == 0 ? A_D0 : A_D1, d); m_rdy[ch] = 1'b0; end
            1: begin rd(ch == 0 ? A_ST0 : A_ST1, d); m_ovr[ch] = 1'b0; end
            default: ;
         endcase
      end

      // asynchronous reset in the middle of a frame
      mon_en = 1'b0;
      wr(A_D0, 8'h00);
      repeat (10) @(negedge clock);
      chk("tx_mid_data", 32'(tx[0]), 32'h0);
      #2 reset = 1'b1;
      #1 chk("tx_async_reset", 32'(tx[0]), 32'h1);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      peek(A_ST0, d);  chk("post_reset_status0", 32'(d), 32'h06);
      peek(A_ST1, d);  chk("post_reset_status1", 32'(d), 32'h06);
      lows = 0;
      repeat (80) begin
         @(negedge clock);
         if (tx !== 2'b11) lows++;
      end
      chk("no_residual_tx", 32'(lows), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      chk("global_timeout", 32'h1, 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $fatal(1, "FAIL global_timeout reached");
   end

endmodule
